vending_controller: RTL and testbench
=====================================

VENDING_CONTROLLER -- requirements
Module: vending_controller

Interface
REQ-001 SHALL have parameter PRICE, default 4, meaning item price in nickel units (1..15).
REQ-002 SHALL have parameter DISPENSE_TIMEOUT, default 8, meaning cycles to wait for io_dispense_ack (1..255).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port io_nickel  input  1  one-cycle nickel coin pulse, +1 unit.
REQ-006 SHALL have port io_dime  input  1  one-cycle dime coin pulse, +2 units.
REQ-007 SHALL have port io_cancel  input  1  one-cycle refund request.
REQ-008 SHALL have port io_dispense_req  output  1  dispense request, held until ack.
REQ-009 SHALL have port io_dispense_ack  input  1  dispenser completion.
REQ-010 SHALL have port io_change_valid  output  1  change payout valid, held until ack.
REQ-011 SHALL have port io_change_nickels  output  4  nickels to return; 0 when io_change_valid low.
REQ-012 SHALL have port io_change_ack  input  1  payout completion.
REQ-013 SHALL have port io_credit  output  4  current credit register, nickel units.
REQ-014 SHALL have port io_coin_reject  output  1  registered one-cycle pulse, coin(s) refused.
REQ-015 SHALL have port io_busy  output  1  high whenever state is not IDLE.
REQ-016 SHALL have port io_fault  output  1  registered one-cycle pulse on dispense timeout.

Function
REQ-017 SHALL implement states IDLE, DISPENSE, CHANGE; all outputs registered or decoded from state/credit only.
REQ-018 SHALL, in IDLE, add coin value (nickel 1, dime 2, both 3) to credit at the sampling edge.
REQ-019 SHALL reject the whole cycle's coins (credit unchanged, io_coin_reject next cycle) if credit+value > 15; no wrap-around.
REQ-020 SHALL reject all coins in DISPENSE and CHANGE with io_coin_reject.
REQ-021 SHALL, in IDLE, move to DISPENSE at the same edge the updated credit reaches >= PRICE; io_dispense_req high the following cycle (1-cycle latency from coin pulse).
REQ-022 SHALL, on io_cancel in IDLE with post-coin credit > 0, move to CHANGE with full credit; cancel wins over REQ-021 in the same cycle.
REQ-023 SHALL ignore io_cancel when credit is 0 or state is not IDLE.
REQ-024 SHALL, in DISPENSE on io_dispense_ack, subtract PRICE from credit; go to CHANGE if remainder > 0, else IDLE.
REQ-025 SHALL, in CHANGE, drive io_change_nickels = credit; on io_change_ack clear credit and return to IDLE.
REQ-026 SHALL ignore io_dispense_ack outside DISPENSE and io_change_ack outside CHANGE.

Reset
REQ-027 SHALL, while reset is low, asynchronously force state IDLE, credit 0, timeout counter 0, and all outputs 0.
REQ-028 SHALL, on reset mid-DISPENSE or mid-CHANGE, discard credit with no payout; first coin accepted on the first rising edge after reset release.

Configuration
REQ-029 SHALL, with VENDING_TIMEOUT_EN defined, count DISPENSE cycles and, when DISPENSE_TIMEOUT cycles elapse without ack, pulse io_fault and move to CHANGE refunding full credit.
REQ-030 SHALL, without VENDING_TIMEOUT_EN, wait in DISPENSE indefinitely, omit the counter, and tie io_fault to 0.

Verification
REQ-031 SHALL cover: PRICE=4, dime,dime on consecutive cycles -> credit 2 then 4, io_dispense_req next cycle; ack -> IDLE, no change, credit 0.
REQ-032 SHALL cover: nickel+dime same cycle then dime -> credit 3 then 5; ack -> io_change_valid with io_change_nickels=1; change ack -> credit 0.
REQ-033 SHALL cover: nickel then io_cancel with dime same cycle -> CHANGE with io_change_nickels=3, no io_dispense_req.
REQ-034 SHALL cover: PRICE=15, credit 14, dime -> io_coin_reject one cycle, credit stays 14; nickel -> dispense.
REQ-035 SHALL cover: VENDING_TIMEOUT_EN, DISPENSE_TIMEOUT=8, credit 4, no ack -> io_fault after 8 cycles, io_change_nickels=4.
REQ-036 SHALL cover: reset asserted in CHANGE with credit 3 -> all outputs 0 immediately, credit 0 after release.

Source files
------------

// File: rtl/vending_controller.sv
// rtl/vending_controller.sv - coin-operated vending controller (IDLE/DISPENSE/CHANGE), optional VENDING_TIMEOUT_EN dispense watchdog
module vending_controller #(
    parameter int PRICE            = 4,
    parameter int DISPENSE_TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       io_nickel,
    input  logic       io_dime,
    input  logic       io_cancel,
    output logic       io_dispense_req,
    input  logic       io_dispense_ack,
    output logic       io_change_valid,
    output logic [3:0] io_change_nickels,
    input  logic       io_change_ack,
    output logic [3:0] io_credit,
    output logic       io_coin_reject,
    output logic       io_busy,
    output logic       io_fault
);

    typedef enum logic [1:0] {IDLE, DISPENSE, CHANGE} state_t;

    localparam logic [3:0] PRICE_U = 4'(PRICE);

    state_t     state, state_next;
    logic [3:0] credit, credit_next;
    logic [3:0] post_credit;
    logic       coin_reject_next;
    logic       timeout_hit;
    logic [1:0] coin_value;
    logic [4:0] coin_sum;
    logic       overflow;

    // Nickel is 1 unit and dime is 2, so the pair forms the coin value directly.
    assign coin_value = {io_dime, io_nickel};
    assign coin_sum   = {1'b0, credit} + {3'b000, coin_value};
    assign overflow   = coin_sum[4];

`ifdef VENDING_TIMEOUT_EN
    logic [7:0] timer;

    assign timeout_hit = (state == DISPENSE) && !io_dispense_ack &&
                         (timer == 8'(DISPENSE_TIMEOUT - 1));

    // Count consecutive DISPENSE cycles; restart on every entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            timer <= 8'd0;
        else if (state == DISPENSE && state_next == DISPENSE)
            timer <= timer + 8'd1;
        else
            timer <= 8'd0;
    end

    // One-cycle fault pulse when the dispenser never acknowledged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            io_fault <= 1'b0;
        else
            io_fault <= timeout_hit;
    end
`else
    assign timeout_hit = 1'b0;
    assign io_fault    = 1'b0;
`endif

    // State, credit and the coin-reject pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            credit         <= 4'd0;
            io_coin_reject <= 1'b0;
        end else begin
            state          <= state_next;
            credit         <= credit_next;
            io_coin_reject <= coin_reject_next;
        end
    end

    // Next state and next credit; an overflowing coin cycle is refused as a whole.
    always_comb begin
        state_next       = state;
        credit_next      = credit;
        coin_reject_next = 1'b0;
        post_credit      = overflow ? credit : coin_sum[3:0];
        case (state)
            IDLE: begin
                coin_reject_next = overflow;
                credit_next      = post_credit;
                if (io_cancel && post_credit != 4'd0)
                    state_next = CHANGE;
                else if (post_credit >= PRICE_U)
                    state_next = DISPENSE;
            end
            DISPENSE: begin
                coin_reject_next = |coin_value;
                if (io_dispense_ack) begin
                    credit_next = credit - PRICE_U;
                    state_next  = (credit_next != 4'd0) ? CHANGE : IDLE;
                end else if (timeout_hit) begin
                    state_next = CHANGE;
                end
            end
            CHANGE: begin
                coin_reject_next = |coin_value;
                if (io_change_ack) begin
                    credit_next = 4'd0;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from state and credit.
    always_comb begin
        io_dispense_req   = (state == DISPENSE);
        io_change_valid   = (state == CHANGE);
        io_change_nickels = (state == CHANGE) ? credit : 4'd0;
        io_credit         = credit;
        io_busy           = (state != IDLE);
    end

endmodule

// File: tb/tb_vending_controller.sv
// tb/tb_vending_controller.sv - directed vector bench for vending_controller
module tb_vending_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       nickel = 1'b0, dime = 1'b0, cancel = 1'b0, dack = 1'b0, cack = 1'b0;
    logic       req, cvalid, rej, busy, fault;
    logic [3:0] cnick, credit;

    logic       nickel2 = 1'b0, dime2 = 1'b0, zero2 = 1'b0;
    logic       req2, cvalid2, rej2, busy2, fault2;
    logic [3:0] cnick2, credit2;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    vending_controller #(.PRICE(4), .DISPENSE_TIMEOUT(8)) u_dut (
        .clk(clk), .reset(reset), .io_nickel(nickel), .io_dime(dime), .io_cancel(cancel),
        .io_dispense_req(req), .io_dispense_ack(dack), .io_change_valid(cvalid),
        .io_change_nickels(cnick), .io_change_ack(cack), .io_credit(credit),
        .io_coin_reject(rej), .io_busy(busy), .io_fault(fault)
    );

    vending_controller #(.PRICE(15), .DISPENSE_TIMEOUT(8)) u_dut15 (
        .clk(clk), .reset(reset), .io_nickel(nickel2), .io_dime(dime2), .io_cancel(zero2),
        .io_dispense_req(req2), .io_dispense_ack(zero2), .io_change_valid(cvalid2),
        .io_change_nickels(cnick2), .io_change_ack(zero2), .io_credit(credit2),
        .io_coin_reject(rej2), .io_busy(busy2), .io_fault(fault2)
    );

    typedef struct {
        logic       n, d, c, da, ca;
        logic [3:0] credit;
        logic       req, cvalid;
        logic [3:0] cnick;
        logic       rej, busy;
    } vec_t;

    vec_t vecs[17];

    // Packed observation: {credit, req, cvalid, cnick, reject, busy, fault}
    function automatic logic [12:0] e(input logic [3:0] cr, input logic rq, input logic cv,
                                      input logic [3:0] cn, input logic rj, input logic bz,
                                      input logic ft);
        return {cr, rq, cv, cn, rj, bz, ft};
    endfunction

    function automatic vec_t mk(input logic n, input logic d, input logic c, input logic da,
                                input logic ca, input logic [3:0] cr, input logic rq,
                                input logic cv, input logic [3:0] cn, input logic rj,
                                input logic bz);
        vec_t v;
        v.n = n; v.d = d; v.c = c; v.da = da; v.ca = ca;
        v.credit = cr; v.req = rq; v.cvalid = cv; v.cnick = cn; v.rej = rj; v.busy = bz;
        return v;
    endfunction

    function automatic logic [12:0] obs();
        return {credit, req, cvalid, cnick, rej, busy, fault};
    endfunction

    function automatic logic [12:0] obs2();
        return {credit2, req2, cvalid2, cnick2, rej2, busy2, fault2};
    endfunction

    task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic n, input logic d, input logic c, input logic da, input logic ca);
        nickel = n; dime = d; cancel = c; dack = da; cack = ca;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //                n  d  c  da ca  cr  rq cv cn  rj bz
        vecs[0]  = mk(0, 1, 0, 0, 0, 2, 0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 1, 0, 0, 0, 4, 1, 0, 0, 0, 1);
        vecs[2]  = mk(0, 0, 0, 0, 0, 4, 1, 0, 0, 0, 1);
        vecs[3]  = mk(1, 0, 0, 0, 0, 4, 1, 0, 0, 1, 1);
        vecs[4]  = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        vecs[5]  = mk(1, 1, 0, 0, 0, 3, 0, 0, 0, 0, 0);
        vecs[6]  = mk(0, 1, 0, 0, 0, 5, 1, 0, 0, 0, 1);
        vecs[7]  = mk(0, 0, 0, 1, 0, 1, 0, 1, 1, 0, 1);
        vecs[8]  = mk(0, 1, 1, 1, 0, 1, 0, 1, 1, 1, 1);
        vecs[9]  = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        vecs[10] = mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        vecs[11] = mk(0, 1, 1, 0, 0, 3, 0, 1, 3, 0, 1);
        vecs[12] = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        vecs[13] = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[14] = mk(0, 1, 0, 0, 0, 2, 0, 0, 0, 0, 0);
        vecs[15] = mk(0, 1, 1, 0, 0, 4, 0, 1, 4, 0, 1);
        vecs[16] = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_p4", obs(), 13'd0);
        check("reset_p15", obs2(), 13'd0);
        #2 reset = 1'b1;
        step();

        // Table-driven vectors on PRICE=4
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].n, vecs[i].d, vecs[i].c, vecs[i].da, vecs[i].ca);
            step();
            check($sformatf("vec%0d", i), obs(),
                  e(vecs[i].credit, vecs[i].req, vecs[i].cvalid, vecs[i].cnick,
                    vecs[i].rej, vecs[i].busy, 1'b0));
        end
        drive(0, 0, 0, 0, 0);

        // PRICE=15 overflow boundary
        for (int i = 0; i < 7; i++) begin
            dime2 = 1'b1;
            step();
        end
        check("p15_credit14", obs2(), e(14, 0, 0, 0, 0, 0, 0));
        step();
        check("p15_dime_reject", obs2(), e(14, 0, 0, 0, 1, 0, 0));
        dime2 = 1'b0;
        step();
        check("p15_reject_one_cycle", obs2(), e(14, 0, 0, 0, 0, 0, 0));
        nickel2 = 1'b1; dime2 = 1'b1;
        step();
        check("p15_both_reject", obs2(), e(14, 0, 0, 0, 1, 0, 0));
        dime2 = 1'b0;
        step();
        check("p15_nickel_dispense", obs2(), e(15, 1, 0, 0, 0, 1, 0));
        nickel2 = 1'b0;

        // Dispense watchdog
        drive(0, 1, 0, 0, 0);
        step();
        step();
        drive(0, 0, 0, 0, 0);
        check("to_enter", obs(), e(4, 1, 0, 0, 0, 1, 0));
        for (int i = 1; i < 8; i++) begin
            step();
            check($sformatf("to_wait%0d", i), obs(), e(4, 1, 0, 0, 0, 1, 0));
        end
        step();
`ifdef VENDING_TIMEOUT_EN
        check("to_fault", obs(), e(4, 0, 1, 4, 0, 1, 1));
        step();
        check("to_fault_pulse", obs(), e(4, 0, 1, 4, 0, 1, 0));
        drive(0, 0, 0, 0, 1);
`else
        check("to_no_fault", obs(), e(4, 1, 0, 0, 0, 1, 0));
        drive(0, 0, 0, 1, 0);
`endif
        step();
        drive(0, 0, 0, 0, 0);
        check("to_exit", obs(), e(0, 0, 0, 0, 0, 0, 0));

        // Reset in CHANGE with credit 3
        drive(1, 1, 1, 0, 0);
        step();
        drive(0, 0, 0, 0, 0);
        check("rst_pre_change", obs(), e(3, 0, 1, 3, 0, 1, 0));
        #2 reset = 1'b0;
        #1;
        check("rst_async_clear", obs(), 13'd0);
        #2 reset = 1'b1;
        drive(1, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0);
        check("rst_first_coin", obs(), e(1, 0, 0, 0, 0, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
